// File: rtl/stall_attributor.sv
// Stall-cause performance counters: each stalled dispatch cycle is attributed to one
// cause by fixed priority, stall episodes are tracked, and all counters are readable by index.
module stall_attributor #(
  parameter int  NUM_CAUSES = 15,
  parameter int  CNT_W      = 32,
  localparam int IDX_W      = $clog2(NUM_CAUSES + 5)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [NUM_CAUSES-1:0] stall_causes,
  input  logic                  dispatch_stall,
  input  logic                  rd_req,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic [CNT_W-1:0]      rd_data,
  output logic                  in_stall,
  output logic [CNT_W-1:0]      max_run
);

  localparam int UNATTR_IDX = NUM_CAUSES;
  localparam int EN_IDX     = NUM_CAUSES + 1;
  localparam int TOTAL_IDX  = NUM_CAUSES + 2;
  localparam int EPI_IDX    = NUM_CAUSES + 3;
  localparam int NUM_CNT    = NUM_CAUSES + 4;
  localparam logic [IDX_W-1:0] MAX_RUN_IDX = IDX_W'(NUM_CAUSES + 4);

  typedef enum logic {IDLE, STALL} state_t;

  state_t                state;
  logic [NUM_CAUSES-1:0] s_causes;
  logic                  s_stall;
  logic                  s_en;
  logic [CNT_W-1:0]      cnt [NUM_CNT];
  logic [CNT_W-1:0]      run;
  logic [CNT_W-1:0]      run_next;
  logic [IDX_W-1:0]      cause_idx;
  logic                  cause_hit;
  logic [CNT_W-1:0]      rd_sel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Clearing the sample stage too means the event presented alongside clr is dropped as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_causes <= '0;
      s_stall  <= 1'b0;
      s_en     <= 1'b0;
    end else if (clr) begin
      s_causes <= '0;
      s_stall  <= 1'b0;
      s_en     <= 1'b0;
    end else begin
      s_causes <= stall_causes;
      s_stall  <= dispatch_stall;
      s_en     <= en;
    end
  end

  always_comb begin
    cause_idx = '0;
    cause_hit = |s_causes;
    for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
      if (s_causes[i]) cause_idx = IDX_W'(i);
    end
  end

  assign run_next = (state == IDLE) ? CNT_W'(1) : sat_inc(run);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
      run     <= '0;
      max_run <= '0;
      state   <= IDLE;
    end else if (clr) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
      run     <= '0;
      max_run <= '0;
      state   <= IDLE;
    end else if (s_en) begin
      cnt[EN_IDX] <= sat_inc(cnt[EN_IDX]);
      if (s_stall) begin
        cnt[TOTAL_IDX] <= sat_inc(cnt[TOTAL_IDX]);
        if (cause_hit) cnt[cause_idx] <= sat_inc(cnt[cause_idx]);
        else           cnt[UNATTR_IDX] <= sat_inc(cnt[UNATTR_IDX]);
        if (state == IDLE) cnt[EPI_IDX] <= sat_inc(cnt[EPI_IDX]);
        state <= STALL;
        run   <= run_next;
        if (run_next > max_run) max_run <= run_next;
      end else begin
        state <= IDLE;
        run   <= '0;
      end
    end
  end

  assign in_stall = (state == STALL);

  always_comb begin
    rd_sel = '0;
    if (rd_idx == MAX_RUN_IDX)     rd_sel = max_run;
    else if (rd_idx < MAX_RUN_IDX) rd_sel = cnt[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_sel;
    end
  end

endmodule

// File: tb/tb_stall_attributor.sv
// Randomized scoreboard bench for stall_attributor; a 32-bit and a 4-bit instance share
// stimulus so saturation is exercised alongside the full-width counters.
module tb_stall_attributor;

  localparam int NC = 15;
  localparam int IW = $clog2(NC + 5);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic          dispatch_stall = 1'b0;
  logic          rd_req = 1'b0;
  logic [NC-1:0] stall_causes = '0;
  logic [IW-1:0] rd_idx = '0;

  logic        rd_valid32, rd_valid4, in_stall32, in_stall4;
  logic [31:0] rd_data32, max_run32;
  logic [3:0]  rd_data4, max_run4;

  stall_attributor #(.NUM_CAUSES(NC), .CNT_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .stall_causes(stall_causes),
    .dispatch_stall(dispatch_stall), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_valid(rd_valid32), .rd_data(rd_data32), .in_stall(in_stall32), .max_run(max_run32)
  );

  stall_attributor #(.NUM_CAUSES(NC), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .stall_causes(stall_causes),
    .dispatch_stall(dispatch_stall), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_valid(rd_valid4), .rd_data(rd_data4), .in_stall(in_stall4), .max_run(max_run4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: unbounded event counts; saturation is applied only when comparing.
  longint m_cause [NC];
  longint m_unattr, m_en_cyc, m_total, m_episodes, m_run, m_max;
  bit     m_in_ep;

  typedef struct {
    bit            en;
    bit            stall;
    logic [NC-1:0] causes;
  } sample_t;

  sample_t pend;
  bit      pend_valid = 1'b0;

  longint rd_q[$];
  bit     exp_stall_q[$];
  longint exp_max_q[$];

  longint mon_raw, mon_max;
  bit     mon_stall;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task model_reset();
    foreach (m_cause[i]) m_cause[i] = 0;
    m_unattr = 0; m_en_cyc = 0; m_total = 0; m_episodes = 0;
    m_run = 0; m_max = 0; m_in_ep = 1'b0;
  endtask

  task model_apply(input sample_t s);
    logic [NC-1:0] lsb;
    if (!s.en) return;
    m_en_cyc++;
    if (!s.stall) begin
      m_in_ep = 1'b0;
      m_run   = 0;
      return;
    end
    m_total++;
    if (s.causes == '0) m_unattr++;
    else begin
      lsb = s.causes & (~s.causes + NC'(1));
      for (int i = 0; i < NC; i++) if (lsb[i]) m_cause[i]++;
    end
    if (!m_in_ep) begin
      m_episodes++;
      m_in_ep = 1'b1;
    end
    m_run++;
    if (m_run > m_max) m_max = m_run;
  endtask

  function automatic longint raw_value(input int idx);
    if (idx < NC)      return m_cause[idx];
    if (idx == NC)     return m_unattr;
    if (idx == NC + 1) return m_en_cyc;
    if (idx == NC + 2) return m_total;
    if (idx == NC + 3) return m_episodes;
    if (idx == NC + 4) return m_max;
    return 0;
  endfunction

  // One cycle of stimulus; the model holds everything sampled two or more edges ago.
  task applyStimulus(input bit e, input bit s, input logic [NC-1:0] c, input bit cl,
                     input bit rq, input int ri);
    @(posedge clk);
    #1;
    exp_stall_q.push_back(m_in_ep);
    exp_max_q.push_back(m_max);
    if (rq) rd_q.push_back(raw_value(ri));
    if (cl) begin
      model_reset();
      pend_valid = 1'b0;
    end else begin
      if (pend_valid) model_apply(pend);
      pend       = '{e, s, c};
      pend_valid = 1'b1;
    end
    en             = e;
    dispatch_stall = s;
    stall_causes   = c;
    clr            = cl;
    rd_req         = rq;
    rd_idx         = IW'(ri);
  endtask

  task resetPulse();
    rst_n          = 1'b0;
    en             = 1'b0;
    dispatch_stall = 1'b0;
    stall_causes   = '0;
    clr            = 1'b0;
    rd_req         = 1'b0;
    rd_q.delete();
    exp_stall_q.delete();
    exp_max_q.delete();
    model_reset();
    pend_valid = 1'b0;
    @(negedge clk);
    checkOutput("reset_rd_valid32", longint'(rd_valid32), 0);
    checkOutput("reset_rd_valid4", longint'(rd_valid4), 0);
    checkOutput("reset_in_stall", longint'(in_stall32), 0);
    checkOutput("reset_max_run", longint'(max_run32), 0);
    @(posedge clk);
    #2;
    checkOutput("reset_rd_valid_held", longint'(rd_valid32), 0);
    rst_n = 1'b1;
  endtask

  task dump_all();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 0);
    for (int i = 0; i <= NC + 5; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, i);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 31);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_stall_q.size() > 0) begin
        mon_stall = exp_stall_q.pop_front();
        mon_max   = exp_max_q.pop_front();
        checkOutput("in_stall32", longint'(in_stall32), longint'(mon_stall));
        checkOutput("in_stall4", longint'(in_stall4), longint'(mon_stall));
        checkOutput("max_run32", longint'(max_run32), sat(mon_max, 32));
        checkOutput("max_run4", longint'(max_run4), sat(mon_max, 4));
      end
      if (rd_valid32 || rd_valid4) begin
        checkOutput("rd_valid_agree", longint'(rd_valid4), longint'(rd_valid32));
        if (rd_q.size() == 0) begin
          checkOutput("rd_valid_unexpected", longint'(rd_valid32 | rd_valid4), 0);
        end else begin
          mon_raw = rd_q.pop_front();
          checkOutput("rd_data32", longint'(rd_data32), sat(mon_raw, 32));
          checkOutput("rd_data4", longint'(rd_data4), sat(mon_raw, 4));
        end
      end
    end
  end

  initial begin
    logic [NC-1:0] rc;
    model_reset();
    resetPulse();

    $display("[TB] idle enabled cycles");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 0);
    dump_all();

    $display("[TB] attributed episode");
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 15'h0005, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 15'h0005, 1'b0, 1'b0, 0);
    dump_all();

    $display("[TB] unattributed episodes");
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, '0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 15'h0100, 1'b0, 1'b0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, '0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 0);
    dump_all();

    $display("[TB] enable dropped mid-episode");
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 15'h0010, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 15'h0010, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 15'h0010, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 0);
    dump_all();

    $display("[TB] saturation and clear during stall");
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 15'h0008, 1'b0, 1'b0, 0);
    dump_all();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 15'h0008, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 15'h0008, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 15'h0008, 1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 15'h0008, 1'b0, 1'b1, NC + 3);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 0);
    dump_all();

    $display("[TB] reads during stalls and reset during read");
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 15'h0042, 1'b0, 1'b1, NC + 2);
    applyStimulus(1'b1, 1'b1, '0, 1'b0, 1'b1, 31);
    applyStimulus(1'b1, 1'b1, '0, 1'b0, 1'b1, NC + 4);
    applyStimulus(1'b1, 1'b1, '0, 1'b0, 1'b1, NC + 2);
    #2;
    resetPulse();
    dump_all();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      rc = NC'($urandom & $urandom);
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0, rc,
                    $urandom_range(0, 49) == 0, $urandom_range(0, 1) != 0,
                    int'($urandom_range(0, 31)));
    end
    dump_all();

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 0);
    @(negedge clk);
    checkOutput("rd_q_drained", longint'(rd_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
